// File: rtl/fwft_fifo_pkg.sv
// Shared helpers for the FWFT FIFO: pointer/count widths, the status-flag
// bundle and the elaboration-time legality checks on the parameters.
package fwft_fifo_pkg;

    typedef struct packed {
        logic full;
        logic prog_full;
        logic prog_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, prog_full: 1'b0, prog_empty: 1'b1};

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit widths_equal(input int rd_w, input int wr_w, input int ram_w);
        return (rd_w == wr_w) && (wr_w == ram_w);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fwft_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port. The array
// itself is never reset; only the read-data register is.
module sdp_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the FIFO output register, so it resets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy and watermark flags.
// Optional: define FWFT_FIFO_DOUT_ZERO_EN to force dout to zero while empty.
module fwft_fifo
    import fwft_fifo_pkg::*;
#(
    parameter int RD_DATA_WIDTH     = 64,
    parameter int WR_DATA_WIDTH     = 64,
    parameter int RAM_DATA_WIDTH    = 64,
    parameter int WR_DEPTH          = 1024,
    parameter int PROG_FULL_THRESH  = WR_DEPTH - 16,
    parameter int PROG_EMPTY_THRESH = 16
) (
    input  logic                               clk,
    input  logic                               global_rst_n,
    input  logic                               wr_en,
    input  logic [WR_DATA_WIDTH-1:0]           din,
    output logic                               full,
    output logic [count_width(WR_DEPTH)-1:0]   elements_wr,
    output logic                               prog_full,
    input  logic                               rd_en,
    output logic [RD_DATA_WIDTH-1:0]           dout,
    output logic                               empty,
    output logic [count_width(WR_DEPTH)-1:0]   elements_rd,
    output logic                               prog_empty
);

    localparam int PW = ptr_width(WR_DEPTH);
    localparam int CW = count_width(WR_DEPTH);

    generate
        if (!widths_equal(RD_DATA_WIDTH, WR_DATA_WIDTH, RAM_DATA_WIDTH)) begin : g_bad_width
            $error("fwft_fifo: RD/WR/RAM data widths must be equal");
        end
        if (!depth_legal(WR_DEPTH)) begin : g_bad_depth
            $error("fwft_fifo: WR_DEPTH must be a power of 2 and at least 4");
        end
    endgenerate

    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             w_count_nxt;
    logic [CW-1:0]             w_ram_count;
    logic                      r_dout_valid;
    logic                      w_dout_valid_nxt;
    fifo_flags_t               r_flags;
    fifo_flags_t               w_flags_nxt;
    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic                      w_ram_rd;
    logic [RAM_DATA_WIDTH-1:0] w_ram_q;

    // The word on dout is counted in r_count but no longer lives in the RAM.
    assign w_wr_acc    = wr_en && !r_flags.full;
    assign w_rd_acc    = rd_en && r_dout_valid;
    assign w_ram_count = r_count - CW'(r_dout_valid);
    assign w_ram_rd    = (w_ram_count != '0) && (!r_dout_valid || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        w_dout_valid_nxt = r_dout_valid;
        if (w_ram_rd) begin
            w_dout_valid_nxt = 1'b1;
        end else if (w_rd_acc) begin
            w_dout_valid_nxt = 1'b0;
        end

        w_flags_nxt            = FLAGS_RESET;
        w_flags_nxt.full       = (w_count_nxt == CW'(WR_DEPTH));
        w_flags_nxt.prog_full  = (w_count_nxt >= CW'(PROG_FULL_THRESH));
        w_flags_nxt.prog_empty = (w_count_nxt <= CW'(PROG_EMPTY_THRESH));
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_flags      <= FLAGS_RESET;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count      <= w_count_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_flags      <= w_flags_nxt;
        end
    end

    sdp_ram #(
        .DATA_WIDTH (RAM_DATA_WIDTH),
        .DEPTH      (WR_DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst_n      (global_rst_n),
        .i_wr_en    (w_wr_acc),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (din),
        .i_rd_en    (w_ram_rd),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (w_ram_q)
    );

`ifdef FWFT_FIFO_DOUT_ZERO_EN
    assign dout = r_dout_valid ? w_ram_q : '0;
`else
    assign dout = w_ram_q;
`endif

    assign empty       = !r_dout_valid;
    assign full        = r_flags.full;
    assign prog_full   = r_flags.prog_full;
    assign prog_empty  = r_flags.prog_empty;
    assign elements_wr = r_count;
    assign elements_rd = r_count;

endmodule

// File: tb/tb_fwft_fifo.sv
// Randomised and directed bench for fwft_fifo, checked against a queue-based
// model where a word becomes visible one edge after the edge that wrote it.
module tb_fwft_fifo;

    localparam int DEPTH = 1024;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          global_rst_n;
    logic          wr_en;
    logic [63:0]   din;
    logic          full;
    logic [CW-1:0] elements_wr;
    logic          prog_full;
    logic          rd_en;
    logic [63:0]   dout;
    logic          empty;
    logic [CW-1:0] elements_rd;
    logic          prog_empty;

    fwft_fifo dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .elements_wr  (elements_wr),
        .prog_full    (prog_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .elements_rd  (elements_rd),
        .prog_empty   (prog_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          t;
    } entry_t;

    entry_t      modelQ[$];
    int          edgeCount;
    logic [63:0] modelHold;
    int          checks;
    int          errors;

    // A word written at edge e is presented only after edge e+1.
    function automatic bit modelEmpty();
        return (modelQ.size() == 0) || (modelQ[0].t == edgeCount);
    endfunction

    function automatic logic [63:0] modelDout();
        if (!modelEmpty()) return modelQ[0].data;
`ifdef FWFT_FIFO_DOUT_ZERO_EN
        return 64'd0;
`else
        return modelHold;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        int occ;
        occ = modelQ.size();
        checkOutput("empty", 64'(empty), 64'(modelEmpty()));
        checkOutput("full", 64'(full), 64'(occ == DEPTH));
        checkOutput("progFull", 64'(prog_full), 64'(occ >= DEPTH - 16));
        checkOutput("progEmpty", 64'(prog_empty), 64'(occ <= 16));
        checkOutput("elementsWr", 64'(elements_wr), 64'(occ));
        checkOutput("elementsRd", 64'(elements_rd), 64'(occ));
        checkOutput("dout", dout, modelDout());
    endtask

    // Drives one cycle, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic wr, input logic [63:0] d, input logic rd);
        bit wrAcc;
        bit rdAcc;
        wr_en = wr;
        din   = d;
        rd_en = rd;
        wrAcc = wr && (modelQ.size() < DEPTH);
        rdAcc = rd && !modelEmpty();
        @(posedge clk);
        edgeCount++;
        if (rdAcc) begin
            modelHold = modelQ[0].data;
            void'(modelQ.pop_front());
        end
        if (wrAcc) modelQ.push_back('{data: d, t: edgeCount});
        #1;
        checkAll();
    endtask

    task automatic doReset();
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        global_rst_n = 1'b0;
        #1;
        modelQ.delete();
        modelHold = 64'd0;
        checkAll();
        @(negedge clk);
        global_rst_n = 1'b1;
    endtask

    initial begin
        logic rdReg;
        logic [63:0] seq;
        checks       = 0;
        errors       = 0;
        edgeCount    = 0;
        modelHold    = 64'd0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        din          = 64'd0;
        global_rst_n = 1'b0;
        #23;
        checkAll();
        @(negedge clk);
        global_rst_n = 1'b1;

        // Fill with 0..1023, probing latency and watermark boundaries.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b0);
            if (i == 0)    checkOutput("firstWriteStillEmpty", 64'(empty), 64'd1);
            if (i == 1)    checkOutput("firstWordVisible", dout, 64'd0);
            if (i == 15)   checkOutput("progEmptyAt16", 64'(prog_empty), 64'd1);
            if (i == 16)   checkOutput("progEmptyAt17", 64'(prog_empty), 64'd0);
            if (i == 1006) checkOutput("progFullAt1007", 64'(prog_full), 64'd0);
            if (i == 1007) checkOutput("progFullAt1008", 64'(prog_full), 64'd1);
        end
        checkOutput("fullAfterFill", 64'(full), 64'd1);
        checkOutput("countAfterFill", 64'(elements_wr), 64'd1024);
        applyStimulus(1'b1, 64'hDEAD, 1'b0);
        checkOutput("overflowIgnored", 64'(elements_wr), 64'd1024);

        // Drain with a registered read enable that trails empty by a cycle.
        rdReg = 1'b0;
        for (int c = 0; c < 1200 && modelQ.size() > 0; c++) begin
            applyStimulus(1'b0, 64'd0, rdReg);
            rdReg = !empty;
        end
        checkOutput("drainDone", 64'(elements_rd), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("underflowIgnored", 64'(elements_rd), 64'd0);
`ifdef FWFT_FIFO_DOUT_ZERO_EN
        checkOutput("doutAfterDrain", dout, 64'd0);
`else
        checkOutput("doutAfterDrain", dout, 64'd1023);
`endif

        // Continuous flow across pointer wrap.
        seq = 64'd0;
        for (int c = 0; c < 3000; c++) begin
            if (!full) begin
                applyStimulus(1'b1, seq, 1'b1);
                seq++;
            end else begin
                applyStimulus(1'b0, 64'd0, 1'b1);
            end
        end

        // Random traffic with write-heavy and read-heavy stretches.
        for (int c = 0; c < 2400; c++) begin
            int wrBias;
            wrBias = (c % 800 < 400) ? 75 : 30;
            applyStimulus($urandom_range(99) < wrBias, {$urandom, $urandom},
                          $urandom_range(99) < 55);
        end

        // Reset at occupancy 500, then check recovery.
        doReset();
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, 64'(i + 7), 1'b0);
        checkOutput("occupancy500", 64'(elements_wr), 64'd500);
        doReset();
        checkOutput("resetEmpty", 64'(empty), 64'd1);
        checkOutput("resetCount", 64'(elements_rd), 64'd0);
        applyStimulus(1'b1, 64'hA5, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("postResetDout", dout, 64'hA5);
        checkOutput("postResetNotEmpty", 64'(empty), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
